// File: rtl/fft_pkg.sv
// Shared FFT constants, the reorder read-FSM state type and the bit-reversal
// helpers used by the output reorder stage and its testbench.
//   LANES  : samples per beat
//   BEATS  : beats per frame
//   N      : points per frame (LANES*BEATS)
//   WIDTH  : signed width of one re/im sample
package fft_pkg;

    localparam int LANES = 16;
    localparam int BEATS = 32;
    localparam int N     = LANES * BEATS;
    localparam int WIDTH = 13;

    typedef enum logic {
        RD_IDLE = 1'b0,
        RD_READ = 1'b1
    } rd_state_t;

    function automatic logic [3:0] bitrev4(input logic [3:0] x);
        logic [3:0] r;
        for (int i = 0; i < 4; i++) begin
            r[i] = x[3-i];
        end
        return r;
    endfunction

    function automatic logic [4:0] bitrev5(input logic [4:0] x);
        logic [4:0] r;
        for (int i = 0; i < 5; i++) begin
            r[i] = x[4-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/fft_reorder_bank.sv
// One frame buffer of the FFT output reorder stage.
// The write port scatters a bit-reversed input beat to its natural-order bin
// addresses; the read port returns LANES contiguous bins (one natural beat).
// The read port is asynchronous so the top can look one cycle ahead and still
// register its outputs.
//   clk      : clock
//   wr_en    : write the beat on wr_re/wr_im this cycle
//   wr_beat  : input beat index (bit-reversed order position)
//   wr_re/im : LANES input samples
//   rd_beat  : natural-order output beat to read
//   rd_re/im : LANES samples of bins rd_beat*LANES .. rd_beat*LANES+LANES-1
// The address map is built from bitrev4/bitrev5, so LANES=16 and BEATS=32.
module fft_reorder_bank #(
    parameter int LANES = fft_pkg::LANES,
    parameter int WIDTH = fft_pkg::WIDTH,
    parameter int BEATS = fft_pkg::BEATS
) (
    input  logic                       clk,
    input  logic                       wr_en,
    input  logic [$clog2(BEATS)-1:0]   wr_beat,
    input  logic signed [WIDTH-1:0]    wr_re [LANES],
    input  logic signed [WIDTH-1:0]    wr_im [LANES],
    input  logic [$clog2(BEATS)-1:0]   rd_beat,
    output logic signed [WIDTH-1:0]    rd_re [LANES],
    output logic signed [WIDTH-1:0]    rd_im [LANES]
);
    import fft_pkg::bitrev4;
    import fft_pkg::bitrev5;

    localparam int LANE_W = $clog2(LANES);
    localparam int BEAT_W = $clog2(BEATS);
    localparam int DEPTH  = LANES * BEATS;
    localparam int ADDR_W = LANE_W + BEAT_W;

    logic signed [WIDTH-1:0] mem_re [DEPTH];
    logic signed [WIDTH-1:0] mem_im [DEPTH];
    logic [ADDR_W-1:0]       wr_addr [LANES];

    // Input beat b, lane l holds bin rev4(l)*32 + rev5(b); store by bin.
    for (genvar l = 0; l < LANES; l++) begin : g_wr_addr
        assign wr_addr[l] = {bitrev4(4'(l)), bitrev5(wr_beat)};
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int l = 0; l < LANES; l++) begin
                mem_re[wr_addr[l]] <= wr_re[l];
                mem_im[wr_addr[l]] <= wr_im[l];
            end
        end
    end

    for (genvar j = 0; j < LANES; j++) begin : g_rd
        assign rd_re[j] = mem_re[{rd_beat, LANE_W'(j)}];
        assign rd_im[j] = mem_im[{rd_beat, LANE_W'(j)}];
    end

endmodule

// File: rtl/fft_reorder.sv
// FFT output reorder: converts frames arriving in bit-reversed beat/lane order
// into natural order using two ping/pong frame buffers.
//   clk, rst            : clock, synchronous active-high reset
//   din_valid           : input beat present (gaps of any length allowed)
//   din_re/din_im       : LANES signed samples, bit-reversed order
//   dout_valid          : output beat present
//   dout_first/last     : output beat 0 / beat BEATS-1 of a frame
//   dout_re/dout_im     : LANES signed samples, natural order; 0 when idle
//   rd_state_dbg        : current read FSM state
// Handshake: no backpressure. An input beat is consumed on every rising edge
// with din_valid=1; an output beat is delivered on every edge with
// dout_valid=1 and the consumer must take it.
module fft_reorder
    import fft_pkg::rd_state_t;
#(
    parameter int LANES = fft_pkg::LANES,
    parameter int WIDTH = fft_pkg::WIDTH,
    parameter int BEATS = fft_pkg::BEATS
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    din_valid,
    input  logic signed [WIDTH-1:0] din_re [LANES],
    input  logic signed [WIDTH-1:0] din_im [LANES],
    output logic                    dout_valid,
    output logic                    dout_first,
    output logic                    dout_last,
    output logic signed [WIDTH-1:0] dout_re [LANES],
    output logic signed [WIDTH-1:0] dout_im [LANES],
    output rd_state_t               rd_state_dbg
);
    import fft_pkg::RD_IDLE;
    import fft_pkg::RD_READ;

    localparam int                BEAT_W    = $clog2(BEATS);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

    // ---------------- write side ----------------
    logic [BEAT_W-1:0] wr_beat;
    logic              wr_bank;
    logic              handoff;

    assign handoff = din_valid && (wr_beat == LAST_BEAT);

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_beat <= '0;
            wr_bank <= 1'b0;
        end else if (din_valid) begin
            wr_beat <= wr_beat + 1'b1;
            if (handoff) begin
                wr_bank <= ~wr_bank;
            end
        end
    end

    // ---------------- read FSM ----------------
    rd_state_t         state_q, state_d;
    logic              rd_bank_q, rd_bank_d;
    logic [BEAT_W-1:0] rd_beat_q, rd_beat_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= RD_IDLE;
            rd_bank_q <= 1'b0;
            rd_beat_q <= '0;
        end else begin
            state_q   <= state_d;
            rd_bank_q <= rd_bank_d;
            rd_beat_q <= rd_beat_d;
        end
    end

    // rd_beat_q is the beat currently on the output registers; the *_d values
    // are the beat that will be shown after the coming edge.
    always_comb begin
        state_d   = state_q;
        rd_bank_d = rd_bank_q;
        rd_beat_d = rd_beat_q;
        if (handoff) begin
            // A completed bank always restarts the drain, including on the
            // edge that shows the previous frame's last beat.
            state_d   = RD_READ;
            rd_bank_d = wr_bank;
            rd_beat_d = '0;
        end else begin
            case (state_q)
                RD_READ: begin
                    if (rd_beat_q == LAST_BEAT) begin
                        state_d = RD_IDLE;
                    end else begin
                        rd_beat_d = rd_beat_q + 1'b1;
                    end
                end
                default: begin
                    state_d = RD_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        dout_valid   = 1'b0;
        dout_first   = 1'b0;
        dout_last    = 1'b0;
        rd_state_dbg = state_q;
        if (state_q == RD_READ) begin
            dout_valid = 1'b1;
            dout_first = (rd_beat_q == '0);
            dout_last  = (rd_beat_q == LAST_BEAT);
        end
    end

    // ---------------- buffers ----------------
    logic signed [WIDTH-1:0] bank0_re [LANES];
    logic signed [WIDTH-1:0] bank0_im [LANES];
    logic signed [WIDTH-1:0] bank1_re [LANES];
    logic signed [WIDTH-1:0] bank1_im [LANES];

    fft_reorder_bank #(.LANES(LANES), .WIDTH(WIDTH), .BEATS(BEATS)) u_bank0 (
        .clk     (clk),
        .wr_en   (din_valid && !wr_bank),
        .wr_beat (wr_beat),
        .wr_re   (din_re),
        .wr_im   (din_im),
        .rd_beat (rd_beat_d),
        .rd_re   (bank0_re),
        .rd_im   (bank0_im)
    );

    fft_reorder_bank #(.LANES(LANES), .WIDTH(WIDTH), .BEATS(BEATS)) u_bank1 (
        .clk     (clk),
        .wr_en   (din_valid && wr_bank),
        .wr_beat (wr_beat),
        .wr_re   (din_re),
        .wr_im   (din_im),
        .rd_beat (rd_beat_d),
        .rd_re   (bank1_re),
        .rd_im   (bank1_im)
    );

    // Output beat 0 is loaded on the hand-off edge from the bank still being
    // written. Its bins (0..15) all come from even input beats, so they are
    // already stored; the final input beat only writes odd-rev5 bins.
    always_ff @(posedge clk) begin
        if (rst || state_d == RD_IDLE) begin
            for (int j = 0; j < LANES; j++) begin
                dout_re[j] <= '0;
                dout_im[j] <= '0;
            end
        end else begin
            for (int j = 0; j < LANES; j++) begin
                dout_re[j] <= rd_bank_d ? bank1_re[j] : bank0_re[j];
                dout_im[j] <= rd_bank_d ? bank1_im[j] : bank0_im[j];
            end
        end
    end

endmodule
